// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel result path: SRAM command codes, writer
// FSM states, image border width and the BMP row-stride helper.
package sobel_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    localparam logic [11:0] BORDER = 12'd2;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FILL  = 2'd1,
        WR_WRITE = 2'd2,
        WR_DONE  = 2'd3
    } wr_state_e;

    // BMP rows are padded to a whole number of 32-bit words
    function automatic logic [12:0] row_stride(input logic [11:0] out_w);
        return ({1'b0, out_w} + 13'd3) & 13'h1FFC;
    endfunction

endpackage

// File: rtl/pixel_word_packer.sv
// Assembles four pixel bytes into a little-endian 32-bit word; lanes not yet
// written stay zero because the word is cleared each time it is handed off.
module pixel_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        wr_en,
    input  logic        flush,
    input  logic [1:0]  lane,
    input  logic [7:0]  data,
    output logic [31:0] word_nxt
);

    logic [31:0] word_q;

    always_comb begin
        word_nxt = word_q;
        if (wr_en) begin
            case (lane)
                2'd0:    word_nxt[7:0]   = data;
                2'd1:    word_nxt[15:8]  = data;
                2'd2:    word_nxt[23:16] = data;
                default: word_nxt[31:24] = data;
            endcase
        end
    end

    // flush wins over wr_en: the completed word leaves through word_nxt
    always_ff @(posedge clk) begin
        if (rst || clear || flush) begin
            word_q <= 32'd0;
        end else if (wr_en) begin
            word_q <= word_nxt;
        end
    end

endmodule

// File: rtl/result_image_data_writer.sv
// Packs edge-detected bytes into 32-bit words and writes them to SRAM row by
// row with BMP padding, handshaking each word with the memory-side done pulse.
module result_image_data_writer
    import sobel_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] image_width,
    input  logic [11:0] image_height,
    input  logic [7:0]  ED_wdata,
    input  logic        ED_wvalid,
    output logic        ED_wready,
    output logic [1:0]  SO_mode,
    output logic [19:0] SO_wpixNum,
    output logic [31:0] SO_wdata,
    input  logic        SO_dtb,
    output logic        frame_done
);

    wr_state_e   state_q;
    logic [11:0] out_w_q;
    logic [11:0] out_h_q;
    logic [11:0] row_q;
    logic [11:0] col_q;
    logic        row_end_q;

    logic        accept;
    logic        at_row_end;
    logic        word_done;
    logic        too_small;
    logic [12:0] stride;
    logic [19:0] word_addr;
    logic [31:0] word_nxt;

    assign accept     = (state_q == WR_FILL) && ED_wvalid;
    assign at_row_end = (col_q == out_w_q - 12'd1);
    assign word_done  = accept && ((col_q[1:0] == 2'd3) || at_row_end);
    assign too_small  = (image_width < 12'd3) || (image_height < 12'd3);
    assign stride     = row_stride(out_w_q);
    // 20-bit context: the row*stride product wraps modulo 2^20
    assign word_addr  = 20'(row_q) * 20'(stride) + 20'({col_q[11:2], 2'b00});

    assign ED_wready  = (state_q == WR_FILL);
    assign SO_mode    = (state_q == WR_WRITE) ? MODE_WRITE : MODE_IDLE;
    assign frame_done = (state_q == WR_DONE);

    pixel_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == WR_IDLE),
        .wr_en    (accept),
        .flush    (word_done),
        .lane     (col_q[1:0]),
        .data     (ED_wdata),
        .word_nxt (word_nxt)
    );

    // geometry is captured once per frame so mid-frame input changes are harmless
    always_ff @(posedge clk) begin
        if (state_q == WR_IDLE && start) begin
            out_w_q <= image_width - BORDER;
            out_h_q <= image_height - BORDER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WR_IDLE;
            row_q      <= 12'd0;
            col_q      <= 12'd0;
            row_end_q  <= 1'b0;
            SO_wpixNum <= 20'd0;
            SO_wdata   <= 32'd0;
        end else begin
            case (state_q)
                WR_IDLE: begin
                    if (start) begin
                        row_q   <= 12'd0;
                        col_q   <= 12'd0;
                        state_q <= too_small ? WR_DONE : WR_FILL;
                    end
                end
                WR_FILL: begin
                    if (accept) begin
                        col_q <= col_q + 12'd1;
                    end
                    if (word_done) begin
                        SO_wdata   <= word_nxt;
                        SO_wpixNum <= word_addr;
                        row_end_q  <= at_row_end;
                        state_q    <= WR_WRITE;
                    end
                end
                WR_WRITE: begin
                    if (SO_dtb) begin
                        if (row_end_q) begin
                            row_q   <= row_q + 12'd1;
                            col_q   <= 12'd0;
                            state_q <= (row_q == out_h_q - 12'd1) ? WR_DONE : WR_FILL;
                        end else begin
                            state_q <= WR_FILL;
                        end
                    end
                end
                default: begin
                    state_q <= WR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_image_data_writer.sv
// Scenario bench for result_image_data_writer: a byte producer and an SRAM
// responder run side by side, words checked against a queue of expected writes.
module tb_result_image_data_writer;

    logic        tb_clk;
    logic        rst;
    logic        start;
    logic [11:0] image_width;
    logic [11:0] image_height;
    logic [7:0]  ED_wdata;
    logic        ED_wvalid;
    logic        ED_wready;
    logic [1:0]  SO_mode;
    logic [19:0] SO_wpixNum;
    logic [31:0] SO_wdata;
    logic        SO_dtb;
    logic        frame_done;

    typedef struct {
        logic [19:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp;
    int  n_fail;

    result_image_data_writer dut (
        .clk          (tb_clk),
        .rst          (rst),
        .start        (start),
        .image_width  (image_width),
        .image_height (image_height),
        .ED_wdata     (ED_wdata),
        .ED_wvalid    (ED_wvalid),
        .ED_wready    (ED_wready),
        .SO_mode      (SO_mode),
        .SO_wpixNum   (SO_wpixNum),
        .SO_wdata     (SO_wdata),
        .SO_dtb       (SO_dtb),
        .frame_done   (frame_done)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte i of the frame (raster order) carries value i+1
    task automatic build_expected(input int w, input int h);
        int ow, oh, stride;
        wr_t e;
        ow = w - 2;
        oh = h - 2;
        stride = ((ow + 3) / 4) * 4;
        for (int r = 0; r < oh; r++) begin
            for (int c0 = 0; c0 < ow; c0 += 4) begin
                e.addr = 20'(r * stride + c0);
                e.data = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    if (c0 + k < ow) e.data[8*k +: 8] = 8'(r * ow + c0 + k + 1);
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive_bytes(input int n, input bit toggle, input string tag);
        int  idx;
        int  guard;
        bit  phase;
        idx = 0;
        guard = 0;
        phase = 1'b1;
        while (idx < n && guard < 5000) begin
            ED_wdata  = 8'(idx + 1);
            ED_wvalid = toggle ? phase : 1'b1;
            phase = ~phase;
            if (ED_wvalid && ED_wready) idx++;
            @(negedge tb_clk);
            guard++;
        end
        ED_wvalid = 1'b0;
        n_cmp++;
        if (idx !== n) begin
            n_fail++;
            $display("FAIL %s bytes_accepted: got %0d expected %0d", tag, idx, n);
        end
    endtask

    task automatic serve_writes(input int nw, input int delay, input string tag);
        wr_t e;
        int  g;
        for (int w = 0; w < nw; w++) begin
            g = 0;
            while (SO_mode !== 2'b10 && g < 2000) begin
                @(negedge tb_clk);
                g++;
            end
            n_cmp++;
            if (SO_mode !== 2'b10) begin
                n_fail++;
                $display("FAIL %s write_request[%0d]: SO_mode got %b expected 10", tag, w, SO_mode);
                return;
            end
            e = exp_q.pop_front();
            n_cmp += 3;
            if (SO_wpixNum !== e.addr) begin
                n_fail++;
                $display("FAIL %s addr[%0d]: got %0d expected %0d", tag, w, SO_wpixNum, e.addr);
            end
            if (SO_wdata !== e.data) begin
                n_fail++;
                $display("FAIL %s data[%0d]: got %h expected %h", tag, w, SO_wdata, e.data);
            end
            if (ED_wready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s wready_in_write[%0d]: got %b expected 0", tag, w, ED_wready);
            end
            for (int i = 0; i < delay; i++) begin
                @(negedge tb_clk);
                if (delay > 1) begin
                    n_cmp++;
                    if (SO_mode !== 2'b10 || SO_wpixNum !== e.addr || SO_wdata !== e.data || ED_wready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s hold[%0d] cycle %0d: mode %b addr %0d data %h wready %b expected 10 %0d %h 0",
                                 tag, w, i, SO_mode, SO_wpixNum, SO_wdata, ED_wready, e.addr, e.data);
                    end
                end
            end
            SO_dtb = 1'b1;
            @(negedge tb_clk);
            SO_dtb = 1'b0;
        end
    endtask

    task automatic run_frame(input int w, input int h, input int delay, input bit toggle, input string tag);
        int nw;
        exp_q.delete();
        build_expected(w, h);
        nw = exp_q.size();
        image_width  = 12'(w);
        image_height = 12'(h);
        start = 1'b1;
        @(negedge tb_clk);
        start = 1'b0;
        fork
            drive_bytes((w - 2) * (h - 2), toggle, tag);
            serve_writes(nw, delay, tag);
        join
        n_cmp += 2;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame_done_pulse: got %b expected 1", tag, frame_done);
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s writes_missing: got %0d left expected 0", tag, exp_q.size());
        end
        @(negedge tb_clk);
        n_cmp += 2;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s frame_done_width: got %b expected 0", tag, frame_done);
        end
        if (SO_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL %s mode_after_frame: got %b expected 00", tag, SO_mode);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge tb_clk);
        n_cmp += 5;
        if (ED_wready !== 1'b0) begin n_fail++; $display("FAIL reset wready: got %b expected 0", ED_wready); end
        if (SO_mode !== 2'b00) begin n_fail++; $display("FAIL reset mode: got %b expected 00", SO_mode); end
        if (SO_wpixNum !== 20'd0) begin n_fail++; $display("FAIL reset addr: got %0d expected 0", SO_wpixNum); end
        if (SO_wdata !== 32'd0) begin n_fail++; $display("FAIL reset data: got %h expected 0", SO_wdata); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        @(negedge tb_clk);
    endtask

    task automatic test_frame_6x6();
        run_frame(6, 6, 1, 1'b0, "frame_6x6");
    endtask

    task automatic test_row_pad_7x4();
        run_frame(7, 4, 1, 1'b0, "row_pad_7x4");
    endtask

    task automatic test_slow_dtb();
        run_frame(6, 6, 10, 1'b0, "slow_dtb");
    endtask

    task automatic test_valid_toggle();
        run_frame(6, 6, 1, 1'b1, "valid_toggle");
    endtask

    task automatic test_reset_mid_write();
        image_width  = 12'd6;
        image_height = 12'd6;
        start = 1'b1;
        @(negedge tb_clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ED_wdata  = 8'(i + 1);
            ED_wvalid = 1'b1;
            @(negedge tb_clk);
        end
        ED_wvalid = 1'b0;
        n_cmp++;
        if (SO_mode !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid_write request: got %b expected 10", SO_mode);
        end
        rst = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
        n_cmp += 4;
        if (SO_mode !== 2'b00) begin n_fail++; $display("FAIL rst_mid_write mode: got %b expected 00", SO_mode); end
        if (ED_wready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_write wready: got %b expected 0", ED_wready); end
        if (SO_wpixNum !== 20'd0) begin n_fail++; $display("FAIL rst_mid_write addr: got %0d expected 0", SO_wpixNum); end
        if (SO_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_mid_write data: got %h expected 0", SO_wdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            n_cmp++;
            if (SO_mode !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_mid_write idle[%0d]: got %b expected 00", i, SO_mode);
            end
        end
        run_frame(6, 6, 1, 1'b0, "after_rst");
    endtask

    task automatic test_small_image();
        image_width  = 12'd2;
        image_height = 12'd6;
        start = 1'b1;
        @(negedge tb_clk);
        start = 1'b0;
        n_cmp += 2;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL small_image frame_done: got %b expected 1", frame_done); end
        if (SO_mode !== 2'b00) begin n_fail++; $display("FAIL small_image mode: got %b expected 00", SO_mode); end
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_clk);
            n_cmp++;
            if (frame_done !== 1'b0 || SO_mode !== 2'b00 || ED_wready !== 1'b0) begin
                n_fail++;
                $display("FAIL small_image after[%0d]: frame_done %b mode %b wready %b expected 0 00 0",
                         i, frame_done, SO_mode, ED_wready);
            end
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        image_width  = 12'd0;
        image_height = 12'd0;
        ED_wdata     = 8'd0;
        ED_wvalid    = 1'b0;
        SO_dtb       = 1'b0;
        @(negedge tb_clk);
        test_reset();
        test_frame_6x6();
        test_row_pad_7x4();
        test_slow_dtb();
        test_valid_toggle();
        test_reset_mid_write();
        test_small_image();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
